uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / data (from serializer) / optional parity / stop.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN (adds brk_req).
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  ser_data,
`ifdef UART_TX_BREAK_EN
   input  logic                  brk_req,
`endif
   output logic                  ser_en,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
`ifdef UART_TX_BREAK_EN
      , BRK
`endif
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             tx_out_q, tx_out_d;
   logic             busy_q, busy_d;
   logic             ser_en_q, ser_en_d;
   logic             frame_done_q, frame_done_d;
   logic             accept;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (brk_req) state_d = BRK;
            else
`endif
            if (data_valid) accept = 1'b1;
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         PARITY: state_d = STOP;
         STOP: begin
            if (data_valid) accept  = 1'b1;
            else            state_d = IDLE;
         end
`ifdef UART_TX_BREAK_EN
         BRK: if (!brk_req) state_d = STOP;
`endif
         default: state_d = IDLE;
      endcase

      // Config is captured only here, so mid-frame changes never leak in.
      if (accept) begin
         state_d   = START;
         par_en_d  = par_en;
         par_bit_d = (^p_data) ^ par_typ;
      end
   end

   // Outputs are decoded from the next state so they land in the same cycle as the state.
   always_comb begin
      tx_out_d     = 1'b1;
      ser_en_d     = 1'b0;
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == STOP);
`ifdef UART_TX_BREAK_EN
      if (state_q == BRK) frame_done_d = 1'b0;
`endif
      case (state_d)
         START: begin
            tx_out_d = 1'b0;
            ser_en_d = 1'b1;
         end
         DATA: begin
            tx_out_d = ser_data;
            ser_en_d = (cnt_d != LAST_BIT);
         end
         PARITY: tx_out_d = par_bit_d;
`ifdef UART_TX_BREAK_EN
         BRK: tx_out_d = 1'b0;
`endif
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         tx_out_q     <= 1'b1;
         busy_q       <= 1'b0;
         ser_en_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         par_en_q     <= par_en_d;
         par_bit_q    <= par_bit_d;
         tx_out_q     <= tx_out_d;
         busy_q       <= busy_d;
         ser_en_q     <= ser_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx_out     = tx_out_q;
   assign busy       = busy_q;
   assign ser_en     = ser_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized self-checking bench for uart_tx_ctrl with an attached serializer model.
module tb_uart_tx_ctrl;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          par_en;
   logic          par_typ;
   logic          ser_data;
   logic          ser_en;
   logic          tx_out;
   logic          busy;
   logic          frame_done;
   logic [DW-1:0] sreg;
   logic [3:0]    obs;
   logic [3:0]    exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(DW), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data),
`ifdef UART_TX_BREAK_EN
      .brk_req(1'b0),
`endif
      .ser_en(ser_en), .tx_out(tx_out), .busy(busy), .frame_done(frame_done));

   // Serializer: shifts LSB-first while enabled, loads the offered byte while idle.
   always @(posedge clk) begin
      if (rst)             sreg <= '0;
      else if (ser_en)     sreg <= sreg >> 1;
      else if (data_valid) sreg <= p_data;
   end
   assign ser_data = sreg[0];
   assign obs = {tx_out, busy, ser_en, frame_done};

   // Expected per-cycle {tx_out, busy, ser_en, frame_done} from the frame format.
   function automatic void add_idle(input int n);
      repeat (n) exp_q.push_back(4'b1000);
   endfunction

   function automatic void add_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
      exp_q.push_back(4'b0110);
      for (int k = 0; k < DW; k++) exp_q.push_back({d[k], 1'b1, (k < DW - 1), 1'b0});
      if (pen) exp_q.push_back({(^d) ^ ptyp, 3'b100});
      exp_q.push_back(4'b1101);
   endfunction

   task automatic test_reset();
      logic [3:0] e;
      rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         e = 4'b1000;
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                             input string nm);
      logic [3:0] e;
      int n;
      exp_q.delete();
      add_frame(d, pen, ptyp);
      add_idle(2);
      n = exp_q.size();
      p_data = d; par_en = pen; par_typ = ptyp; data_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         data_valid = 1'b0;
         p_data  = DW'($urandom);
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %b want %b", nm, i, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                    input logic pen, input logic ptyp);
      logic [3:0] e;
      int n, l1;
      exp_q.delete();
      add_frame(d1, pen, ptyp);
      l1 = exp_q.size();
      add_frame(d2, pen, ptyp);
      add_idle(2);
      n = exp_q.size();
      p_data = d1; par_en = pen; par_typ = ptyp; data_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 0)  p_data = d2;
         if (i == l1) data_valid = 1'b0;
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [3:0] e;
      exp_q.delete();
      add_frame(8'h5A, 1'b1, 1'b0);
      p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         data_valid = 1'b0;
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL pre_rst cyc %0d: got %b want %b", i, obs, e);
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      e = 4'b1000;
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL rst_abort: got %b want %b", obs, e);
      end
      test_frame(8'h01, 1'b0, 1'b0, "post_rst_frame");
   endtask

   task automatic test_ignore_busy();
      logic [3:0] e;
      int n;
      exp_q.delete();
      add_frame(8'hC3, 1'b1, 1'b0);
      add_idle(3);
      n = exp_q.size();
      p_data = 8'hC3; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         data_valid = (i == 4);
         if (i == 4) p_data = 8'h77;
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL ignore_busy cyc %0d: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 3) == 0)
            test_back_to_back(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
         else
            test_frame(DW'($urandom), 1'($urandom), 1'($urandom), "random_frame");
      end
   endtask

   initial begin
      test_reset();
      test_frame(8'hA5, 1'b1, 1'b0, "a5_even");
      test_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
      test_frame(8'hA5, 1'b0, 1'b0, "a5_nopar");
      test_back_to_back(8'h3C, 8'hFF, 1'b0, 1'b0);
      test_back_to_back(8'h3C, 8'hFF, 1'b1, 1'b1);
      test_reset_midframe();
      test_ignore_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
